laser_shot_controller: RTL and testbench
========================================

LASER_SHOT_CONTROLLER -- requirements
Module: laser_shot_controller

Interface
REQ-001 Parameter FIRE_LEN, default 4: laser fire pulse width, ref_clk cycles, range 1..255.
REQ-002 Parameter BLANK, default 8: echo blanking interval from first fire cycle, cycles, BLANK >= FIRE_LEN.
REQ-003 Parameter WINDOW, default 50000: listen window length from first fire cycle, cycles, BLANK < WINDOW <= 65535.
REQ-004 Parameter HOLDOFF, default 32: post-shot quiet interval, cycles, range 1..65535.
REQ-005 ref_clk  in  1  sole clock, all logic on rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 start  in  1  shot request, 1-cycle pulse, honoured only in IDLE.
REQ-008 echo  in  1  comparator echo, 1-cycle pulse already resynchronised to ref_clk.
REQ-009 laser_fire  out  1  registered laser trigger, active-high.
REQ-010 busy  out  1  high in every state except IDLE.
REQ-011 tof_count  out  16  captured time of flight, cycles from first fire cycle.
REQ-012 tof_valid  out  1  1-cycle strobe, tof_count updated.
REQ-013 timeout  out  1  1-cycle strobe, window expired with no echo.

Function
REQ-014 FSM states SHALL be IDLE, FIRE, LISTEN, HOLDOFF; one 16-bit counter cnt SHALL serve all timed states.
REQ-015 IDLE: start=1 at edge T -> FIRE at T+1, cnt=0, laser_fire high for cycles T+1..T+FIRE_LEN exactly.
REQ-016 FIRE -> LISTEN when cnt==FIRE_LEN-1; cnt SHALL keep counting, not clear, across FIRE->LISTEN.
REQ-017 echo SHALL be accepted only in LISTEN with cnt>=BLANK; echo in IDLE, FIRE, HOLDOFF or during blanking SHALL be ignored.
REQ-018 Accepted echo at cnt value N -> next cycle tof_count=N, tof_valid=1 for one cycle, state HOLDOFF, cnt=0.
REQ-019 LISTEN with cnt==WINDOW-1 and no accepted echo -> next cycle timeout=1 for one cycle, tof_count unchanged, state HOLDOFF, cnt=0.
REQ-020 Echo accepted on cnt==WINDOW-1 SHALL win: tof_valid asserts, timeout does not.
REQ-021 HOLDOFF -> IDLE when cnt==HOLDOFF-1; busy falls the same edge.
REQ-022 start outside IDLE SHALL be dropped, not queued; start in the cycle busy falls SHALL be ignored, next start accepted from IDLE.
REQ-023 tof_valid and timeout SHALL never assert together; at most one of them per shot.
REQ-024 tof_count SHALL hold its value until the next accepted echo.
REQ-025 cnt SHALL never wrap; all compares are equality on 16-bit unsigned.

Reset
REQ-026 reset low SHALL asynchronously force IDLE, cnt=0, laser_fire=0, busy=0, tof_count=0, tof_valid=0, timeout=0.
REQ-027 reset asserted mid-FIRE SHALL drop laser_fire immediately with no strobe on release.
REQ-028 First start accepted SHALL be on the first rising edge after reset release.

Structure
REQ-029 State encodings (2-bit) and parameter defaults SHALL live in the shared rangefinder_pkg.
REQ-030 Single module, no sub-module; echo synchronisation through pulse_cross_domain SHALL be instantiated at the parent level, not inside.
REQ-031 All outputs SHALL be driven from flops, no combinational path from input to output.

Verification
REQ-032 Defaults, start pulse at edge 10 -> laser_fire high edges 11..14, busy high from 11.
REQ-033 Echo at cnt=120 -> tof_valid one cycle later, tof_count=120, IDLE after 32 further cycles.
REQ-034 Echo at cnt=3 and cnt=7 (blanked), none after, WINDOW=200 -> timeout strobe at cnt 199+1, tof_count unchanged.
REQ-035 WINDOW=200, echo exactly at cnt=199 -> tof_valid=1, tof_count=199, timeout=0.
REQ-036 start repeated every cycle during shot -> exactly one fire pulse per shot, second shot only after busy low.
REQ-037 reset low at fire cycle 2 -> laser_fire=0 same cycle, all outputs at reset values, no strobes after release.

Source files
------------

// File: rtl/rangefinder_pkg.sv
// Shared definitions for the rangefinder front end.
// Holds the 2-bit shot-controller state encoding, the default timing
// parameters (all in ref_clk cycles) and a helper that turns a cycle
// count into the terminal value of a 16-bit up-counter.
package rangefinder_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_FIRE    = 2'd1,
        S_LISTEN  = 2'd2,
        S_HOLDOFF = 2'd3
    } shot_state_t;

    localparam int unsigned DEF_FIRE_LEN = 4;
    localparam int unsigned DEF_BLANK    = 8;
    localparam int unsigned DEF_WINDOW   = 50000;
    localparam int unsigned DEF_HOLDOFF  = 32;

    // Last counter value of an interval of n cycles that starts at 0.
    function automatic logic [15:0] last_cnt(input int unsigned n);
        return 16'(n - 1);
    endfunction

endpackage

// File: rtl/laser_shot_controller.sv
// Laser shot sequencer for a time-of-flight rangefinder.
// A start pulse in IDLE fires the laser for FIRE_LEN cycles, then the block
// listens for an echo until WINDOW cycles after the first fire cycle, ignoring
// echoes during the first BLANK cycles. An accepted echo latches the time of
// flight; no echo yields a timeout strobe. A HOLDOFF quiet interval follows
// every shot before another start is honoured.
//
// Ports
//   ref_clk     in   sole clock, rising edge
//   reset       in   asynchronous active-low reset
//   start       in   shot request pulse, honoured only in IDLE
//   echo        in   echo pulse, already synchronous to ref_clk
//   laser_fire  out  laser trigger (registered)
//   busy        out  high outside IDLE (registered)
//   tof_count   out  time of flight in cycles from first fire cycle
//   tof_valid   out  1-cycle strobe, tof_count updated
//   timeout     out  1-cycle strobe, window expired without echo
//
// state   | meaning
// --------+---------------------------------------------------
// IDLE    | waiting for start, counter parked at 0
// FIRE    | laser on, counter runs from 0 to FIRE_LEN-1
// LISTEN  | laser off, counter keeps running, echo sampled
// HOLDOFF | quiet interval, counter restarted at 0
module laser_shot_controller
    import rangefinder_pkg::*;
#(
    parameter int unsigned FIRE_LEN = DEF_FIRE_LEN,
    parameter int unsigned BLANK    = DEF_BLANK,
    parameter int unsigned WINDOW   = DEF_WINDOW,
    parameter int unsigned HOLDOFF  = DEF_HOLDOFF
) (
    input  logic        ref_clk,
    input  logic        reset,
    input  logic        start,
    input  logic        echo,
    output logic        laser_fire,
    output logic        busy,
    output logic [15:0] tof_count,
    output logic        tof_valid,
    output logic        timeout
);

    localparam logic [15:0] FIRE_LAST    = last_cnt(FIRE_LEN);
    localparam logic [15:0] WINDOW_LAST  = last_cnt(WINDOW);
    localparam logic [15:0] HOLDOFF_LAST = last_cnt(HOLDOFF);
    localparam logic [15:0] BLANK_CNT    = 16'(BLANK);

    shot_state_t state_q;
    logic [15:0] cnt_q;
    logic        laser_q;
    logic        busy_q;
    logic [15:0] tof_q;
    logic        tof_valid_q;
    logic        timeout_q;

    always_ff @(posedge ref_clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            laser_q     <= 1'b0;
            busy_q      <= 1'b0;
            tof_q       <= '0;
            tof_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            tof_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q <= S_FIRE;
                        cnt_q   <= '0;
                        laser_q <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                S_FIRE: begin
                    // Counter is not cleared here: LISTEN measures from the
                    // first fire cycle.
                    cnt_q <= cnt_q + 16'd1;
                    if (cnt_q == FIRE_LAST) begin
                        state_q <= S_LISTEN;
                        laser_q <= 1'b0;
                    end
                end
                S_LISTEN: begin
                    // Echo is checked before window expiry so that an echo on
                    // the last window cycle still counts as a hit.
                    if (echo && (cnt_q >= BLANK_CNT)) begin
                        state_q     <= S_HOLDOFF;
                        tof_q       <= cnt_q;
                        tof_valid_q <= 1'b1;
                        cnt_q       <= '0;
                    end else if (cnt_q == WINDOW_LAST) begin
                        state_q   <= S_HOLDOFF;
                        timeout_q <= 1'b1;
                        cnt_q     <= '0;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                S_HOLDOFF: begin
                    if (cnt_q == HOLDOFF_LAST) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    cnt_q   <= '0;
                    laser_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign laser_fire = laser_q;
    assign busy       = busy_q;
    assign tof_count  = tof_q;
    assign tof_valid  = tof_valid_q;
    assign timeout    = timeout_q;

endmodule

// File: tb/tb_laser_shot_controller.sv
// Directed bench: instance a uses default timing, instance b a 200-cycle
// listen window. Sample k denotes 1 time unit after the k-th edge following
// the edge that accepted start; the counter value equals k in FIRE/LISTEN.
module tb_laser_shot_controller;

    logic        ref_clk = 1'b0;
    logic        reset;
    logic        start_a, echo_a, start_b, echo_b;
    logic        laser_a, busy_a, tof_valid_a, timeout_a;
    logic        laser_b, busy_b, tof_valid_b, timeout_b;
    logic [15:0] tof_count_a, tof_count_b;

    int vectors = 0;
    int errors  = 0;

    always #5 ref_clk = ~ref_clk;

    laser_shot_controller u_a (
        .ref_clk    (ref_clk),
        .reset      (reset),
        .start      (start_a),
        .echo       (echo_a),
        .laser_fire (laser_a),
        .busy       (busy_a),
        .tof_count  (tof_count_a),
        .tof_valid  (tof_valid_a),
        .timeout    (timeout_a)
    );

    laser_shot_controller #(.WINDOW(200)) u_b (
        .ref_clk    (ref_clk),
        .reset      (reset),
        .start      (start_b),
        .echo       (echo_b),
        .laser_fire (laser_b),
        .busy       (busy_b),
        .tof_count  (tof_count_b),
        .tof_valid  (tof_valid_b),
        .timeout    (timeout_b)
    );

    task automatic tick();
        @(posedge ref_clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $fatal(1, "FAIL watchdog: time limit reached");
    end

    initial begin
        int rises;
        int touts;
        int vals;
        int noise;
        logic prev;

        reset = 1'b0; start_a = 1'b0; echo_a = 1'b0; start_b = 1'b0; echo_b = 1'b0;
        repeat (3) tick();
        chk1 ("rst_laser_a",   laser_a,     1'b0);
        chk1 ("rst_busy_a",    busy_a,      1'b0);
        chk1 ("rst_tofv_a",    tof_valid_a, 1'b0);
        chk1 ("rst_tout_a",    timeout_a,   1'b0);
        chk16("rst_tof_a",     tof_count_a, 16'd0);
        chk1 ("rst_busy_b",    busy_b,      1'b0);

        // Release reset with start already high: first edge must accept it.
        reset = 1'b1; start_a = 1'b1;
        tick(); start_a = 1'b0;                       // k0
        chk1("a_fire_k0", laser_a, 1'b1);
        chk1("a_busy_k0", busy_a,  1'b1);
        tick(); chk1("a_fire_k1", laser_a, 1'b1);
        tick(); chk1("a_fire_k2", laser_a, 1'b1);
        tick(); chk1("a_fire_k3", laser_a, 1'b1);
        echo_a = 1'b1;                                // echo during FIRE
        tick(); echo_a = 1'b0;                        // k4
        chk1("a_fire_k4",  laser_a,     1'b0);
        chk1("a_busy_k4",  busy_a,      1'b1);
        chk1("a_fire_echo_ignored", tof_valid_a, 1'b0);
        repeat (3) tick();                            // k7
        echo_a = 1'b1;                                // echo during blanking
        tick(); echo_a = 1'b0;                        // k8
        chk1("a_blank_echo_ignored", tof_valid_a, 1'b0);
        repeat (112) tick();                          // k120
        echo_a = 1'b1;
        tick(); echo_a = 1'b0;                        // k121
        chk1 ("a_tofv_k121", tof_valid_a, 1'b1);
        chk16("a_tof_k121",  tof_count_a, 16'd120);
        chk1 ("a_tout_k121", timeout_a,   1'b0);
        tick();                                       // k122
        chk1 ("a_tofv_k122", tof_valid_a, 1'b0);
        chk16("a_tof_hold",  tof_count_a, 16'd120);
        repeat (30) tick();                           // k152
        chk1 ("a_busy_k152", busy_a, 1'b1);
        tick();                                       // k153
        chk1 ("a_busy_k153", busy_a, 1'b0);
        chk16("a_tof_idle",  tof_count_a, 16'd120);

        // Window expiry on b, blanked echoes at cnt 3 and 7.
        start_b = 1'b1;
        tick(); start_b = 1'b0;                       // k0
        chk1("b_busy_k0", busy_b, 1'b1);
        repeat (3) tick(); echo_b = 1'b1;             // k3
        tick(); echo_b = 1'b0;                        // k4
        repeat (3) tick(); echo_b = 1'b1;             // k7
        tick(); echo_b = 1'b0;                        // k8
        chk1("b_blank_echo_ignored", tof_valid_b, 1'b0);
        repeat (191) tick();                          // k199
        chk1("b_busy_k199", busy_b,    1'b1);
        chk1("b_tout_k199", timeout_b, 1'b0);
        tick();                                       // k200
        chk1 ("b_tout_k200", timeout_b,   1'b1);
        chk1 ("b_tofv_k200", tof_valid_b, 1'b0);
        chk16("b_tof_k200",  tof_count_b, 16'd0);
        tick();                                       // k201
        chk1 ("b_tout_k201", timeout_b, 1'b0);
        repeat (31) tick();                           // k232
        chk1 ("b_busy_k232", busy_b, 1'b0);

        // Echo on the last window cycle wins over timeout.
        start_b = 1'b1;
        tick(); start_b = 1'b0;                       // k0
        repeat (199) tick();                          // k199
        echo_b = 1'b1;
        tick(); echo_b = 1'b0;                        // k200
        chk1 ("b_edge_tofv", tof_valid_b, 1'b1);
        chk16("b_edge_tof",  tof_count_b, 16'd199);
        chk1 ("b_edge_tout", timeout_b,   1'b0);
        tick();                                       // k201
        chk1 ("b_edge_tofv_k201", tof_valid_b, 1'b0);
        chk1 ("b_edge_tout_k201", timeout_b,   1'b0);
        repeat (31) tick();                           // k232
        chk1 ("b_edge_busy_k232", busy_b, 1'b0);

        // start held high for a whole shot: one pulse, restart only from IDLE.
        start_b = 1'b1;
        tick();                                       // k0
        chk1("b_hold_fire_k0", laser_b, 1'b1);
        prev = laser_b; rises = 0; touts = 0; vals = 0;
        for (int k = 1; k <= 232; k++) begin
            tick();
            if (laser_b && !prev) rises++;
            if (timeout_b) touts++;
            if (tof_valid_b) vals++;
            prev = laser_b;
        end
        chk16("b_hold_extra_fires", 16'(rises), 16'd0);
        chk16("b_hold_timeouts",    16'(touts), 16'd1);
        chk16("b_hold_tofvalids",   16'(vals),  16'd0);
        chk1 ("b_hold_busy_k232",   busy_b,     1'b0);
        tick();                                       // k233
        chk1 ("b_hold_busy_k233",  busy_b,  1'b1);
        chk1 ("b_hold_laser_k233", laser_b, 1'b1);
        start_b = 1'b0;

        // Reset during the second fire cycle of a.
        start_a = 1'b1;
        tick(); start_a = 1'b0;                       // k0
        tick();                                       // k1
        chk1("a_mid_laser_before", laser_a, 1'b1);
        #2 reset = 1'b0;
        #1;
        chk1 ("a_mid_laser", laser_a,     1'b0);
        chk1 ("a_mid_busy",  busy_a,      1'b0);
        chk16("a_mid_tof",   tof_count_a, 16'd0);
        chk1 ("b_mid_busy",  busy_b,      1'b0);
        chk16("b_mid_tof",   tof_count_b, 16'd0);
        repeat (2) tick();
        reset = 1'b1;
        noise = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (laser_a || busy_a || tof_valid_a || timeout_a) noise++;
            if (laser_b || busy_b || tof_valid_b || timeout_b) noise++;
        end
        chk16("post_reset_activity", 16'(noise), 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
